button_program_selector: RTL and testbench

//  Parametrised front end that turns raw pushbuttons into a registered program-select code for the RISC labkit.
//  - Per channel: 2-flop synchroniser, counter debounce, rising-edge detect, priority encode.
//  - Two modes: momentary with a guaranteed minimum hold, or latched until cleared.
//  - Output feeds the program_selector input of regfile.
//  - Replaces the per-button debounce instances and the top-level selector always-block.

---
 rtl/button_program_selector.sv | 122 ++++++++++++
 tb/tb_button_program_selector.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_program_selector.sv
// Pushbutton front end: per-channel synchroniser, counter debounce and rising-edge
// detect, feeding a priority-encoded, registered program-select code.
module button_program_selector #(
    parameter int NUM_BTN         = 5,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SEL_W           = 32,
    parameter int LATCH_MODE      = 0,
    parameter int PULSE_STRETCH   = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_in,
    input  logic               clear,
    output logic [NUM_BTN-1:0] btn_clean,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [SEL_W-1:0]   program_selector,
    output logic               sel_valid,
    output logic               sel_changed
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // +2 keeps the stretch counter at least one bit wide when PULSE_STRETCH is 0
    localparam int STR_W = $clog2(PULSE_STRETCH + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [STR_W-1:0] STR_LOAD = STR_W'(PULSE_STRETCH);

    logic [NUM_BTN-1:0] sync_1;
    logic [NUM_BTN-1:0] sync_2;
    logic [NUM_BTN-1:0] clean_d;
    logic [CNT_W-1:0]   db_cnt [NUM_BTN];
    logic [STR_W-1:0]   stretch;
    logic [STR_W-1:0]   stretch_next;
    logic [SEL_W-1:0]   sel_next;
    logic [SEL_W-1:0]   sel_prev;
    logic [SEL_W-1:0]   clean_code;
    logic [SEL_W-1:0]   press_code;

    function automatic logic [SEL_W-1:0] encode(input logic [NUM_BTN-1:0] v);
        logic [SEL_W-1:0] code;
        code = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (v[i]) code = SEL_W'(i + 1);
        end
        return code;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= btn_in;
            sync_2 <= sync_1;
        end
    end

    // Counter only runs while the synchronised level disagrees with the clean level
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_BTN; i++) begin
            if (reset) begin
                db_cnt[i]    <= '0;
                btn_clean[i] <= 1'b0;
            end else if (sync_2[i] == btn_clean[i]) begin
                db_cnt[i] <= '0;
            end else if (db_cnt[i] == CNT_LAST) begin
                btn_clean[i] <= sync_2[i];
                db_cnt[i]    <= '0;
            end else begin
                db_cnt[i] <= db_cnt[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            clean_d   <= '0;
            btn_press <= '0;
        end else begin
            clean_d   <= btn_clean;
            btn_press <= btn_clean & ~clean_d;
        end
    end

    assign clean_code = encode(btn_clean);
    assign press_code = encode(btn_press);

    always_comb begin
        sel_next     = program_selector;
        stretch_next = stretch;
        if (LATCH_MODE != 0) begin
            stretch_next = '0;
            if (|btn_press) begin
                sel_next = press_code;
            end else if (clear) begin
                sel_next = '0;
            end
        end else if (|btn_clean) begin
            sel_next     = clean_code;
            stretch_next = STR_LOAD;
        end else if (stretch != '0) begin
            stretch_next = stretch - 1'b1;
        end else begin
            sel_next = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            program_selector <= '0;
            stretch          <= '0;
            sel_prev         <= '0;
            sel_valid        <= 1'b0;
            sel_changed      <= 1'b0;
        end else begin
            program_selector <= sel_next;
            stretch          <= stretch_next;
            sel_prev         <= program_selector;
            sel_valid        <= |program_selector;
            sel_changed      <= (program_selector != sel_prev);
        end
    end

endmodule

// File: tb/tb_button_program_selector.sv
// Bench for button_program_selector: momentary and latched instances share stimulus,
// checked every cycle against a run-length behavioural model plus directed literal checks.
module tb_button_program_selector;
    localparam int NB = 5;
    localparam int DC = 4;
    localparam int SW = 32;
    localparam int PS = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic [NB-1:0] btn_in = '0;

    logic [NB-1:0] clean0, press0, clean1, press1;
    logic [SW-1:0] sel0, sel1;
    logic          valid0, valid1, chg0, chg1;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    button_program_selector #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(DC), .SEL_W(SW),
                              .LATCH_MODE(0), .PULSE_STRETCH(PS)) dut0 (
        .clock(clock), .reset(reset), .btn_in(btn_in), .clear(clear),
        .btn_clean(clean0), .btn_press(press0), .program_selector(sel0),
        .sel_valid(valid0), .sel_changed(chg0));

    button_program_selector #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(DC), .SEL_W(SW),
                              .LATCH_MODE(1), .PULSE_STRETCH(PS)) dut1 (
        .clock(clock), .reset(reset), .btn_in(btn_in), .clear(clear),
        .btn_clean(clean1), .btn_press(press1), .program_selector(sel1),
        .sel_valid(valid1), .sel_changed(chg1));

    // Behavioural model: debounce as "s2 held the same value for DC edges in a row"
    logic [NB-1:0] m_s1, m_s2, m_last, m_clean, m_clean_prev, m_press;
    int            m_run [NB];
    int            m_hold;
    logic [SW-1:0] m_sel [2];
    logic [SW-1:0] m_sel_prev [2];
    logic          m_valid [2];
    logic          m_chg [2];

    function automatic logic [SW-1:0] first_code(input logic [NB-1:0] v);
        for (int i = 0; i < NB; i++) if (v[i]) return SW'(i + 1);
        return '0;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_last = '0; m_clean = '0; m_clean_prev = '0; m_press = '0;
            m_hold = 0;
            for (int i = 0; i < NB; i++) m_run[i] = 0;
            for (int k = 0; k < 2; k++) begin
                m_sel[k] = '0; m_sel_prev[k] = '0; m_valid[k] = 1'b0; m_chg[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_valid[k]    = (m_sel[k] != '0);
                m_chg[k]      = (m_sel[k] != m_sel_prev[k]);
                m_sel_prev[k] = m_sel[k];
            end
            if (m_clean != '0) begin
                m_sel[0] = first_code(m_clean);
                m_hold   = PS;
            end else if (m_hold > 0) begin
                m_hold = m_hold - 1;
            end else begin
                m_sel[0] = '0;
            end
            if (m_press != '0) m_sel[1] = first_code(m_press);
            else if (clear) m_sel[1] = '0;
            m_press      = m_clean & ~m_clean_prev;
            m_clean_prev = m_clean;
            for (int i = 0; i < NB; i++) begin
                m_run[i]  = (m_s2[i] == m_last[i]) ? m_run[i] + 1 : 1;
                m_last[i] = m_s2[i];
                if (m_s2[i] != m_clean[i] && m_run[i] >= DC) m_clean[i] = m_s2[i];
            end
            m_s2 = m_s1;
            m_s1 = btn_in;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clock) begin
        check("dut0_outputs", {clean0, press0, sel0, valid0, chg0},
              {m_clean, m_press, m_sel[0], m_valid[0], m_chg[0]});
        check("dut1_outputs", {clean1, press1, sel1, valid1, chg1},
              {m_clean, m_press, m_sel[1], m_valid[1], m_chg[1]});
    end

    int press0_cnt = 0;
    int chg0_cnt   = 0;
    always @(negedge clock) begin
        if (press0[0]) press0_cnt++;
        if (chg0) chg0_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        int n;
        logic seen;

        tick(3);
        check("reset_sel0", sel0, 0);
        check("reset_sel1", sel1, 0);
        check("reset_flags", {clean0, press0, valid0, chg0, valid1, chg1}, 0);
        reset = 1'b0;
        tick(2);

        // Bounce on channel 0, final raw edge at c=8, then held high
        press0_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            btn_in[0] = ((c % 4) < 2);
            tick(1);
        end
        n = 2;
        while (!clean0[0] && n < 20) begin
            tick(1);
            n++;
        end
        check("bounce_latency", n, 2 + DC);
        tick(5);
        check("bounce_press_count", press0_cnt, 1);
        btn_in = '0;
        tick(20);

        // Glitch of 3 cycles on channel 1
        seen = 1'b0;
        btn_in[1] = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (c == 3) btn_in[1] = 1'b0;
            tick(1);
            if (clean0[1] || press0[1] || sel0 != '0) seen = 1'b1;
        end
        check("glitch_rejected", seen, 0);

        // Priority in momentary mode
        btn_in[1] = 1'b1;
        btn_in[3] = 1'b1;
        tick(8);
        check("priority_both", sel0, 2);
        btn_in[1] = 1'b0;
        tick(8);
        check("priority_after_drop", sel0, 4);
        btn_in = '0;
        tick(20);

        // Stretch: code survives 1 cycle of pipeline latency plus PS stretch cycles
        chg0_cnt = 0;
        btn_in[2] = 1'b1;
        tick(10);
        btn_in[2] = 1'b0;
        n = 0;
        while (clean0[2] && n < 20) begin
            tick(1);
            n++;
        end
        check("stretch_clean_fall", clean0[2], 0);
        n = 0;
        while (sel0 == 3 && n < 20) begin
            tick(1);
            n++;
        end
        check("stretch_hold_cycles", n, PS + 1);
        check("stretch_sel_zero", sel0, 0);
        tick(3);
        check("stretch_changed_count", chg0_cnt, 2);

        // Latched mode
        btn_in[4] = 1'b1;
        tick(8);
        btn_in[4] = 1'b0;
        tick(15);
        check("latch_persist", sel1, 5);
        check("latch_momentary_cleared", sel0, 0);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("latch_clear", sel1, 0);
        btn_in[0] = 1'b1;
        n = 0;
        while (!press1[0] && n < 20) begin
            tick(1);
            n++;
        end
        check("latch_press_seen", press1[0], 1);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("latch_press_beats_clear", sel1, 1);
        btn_in = '0;
        tick(20);

        // Reset while channel 0 counter sits at DC-1, button kept held
        btn_in[0] = 1'b1;
        tick(5);
        check("reset_pre_clean", clean0[0], 0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("reset_no_clean", clean0[0], 0);
        n = 0;
        while (!clean0[0] && n < 20) begin
            tick(1);
            n++;
        end
        check("reset_redetect_latency", n, 2 + DC);
        tick(1);
        check("reset_sel0", sel0, 1);
        check("reset_fresh_press", press0[0], 1);
        tick(1);
        check("reset_sel1", sel1, 1);
        btn_in = '0;
        tick(20);

        // Randomised traffic, checked by the per-cycle compare
        repeat (3000) begin
            for (int i = 0; i < NB; i++)
                if ($urandom_range(0, 9) == 0) btn_in[i] = ~btn_in[i];
            clear = ($urandom_range(0, 11) == 0);
            reset = ($urandom_range(0, 399) == 0);
            tick(1);
        end
        reset = 1'b0;
        clear = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
